// File: rtl/mips_lsu_if.sv
// ---------------------------------------------------------------------------
// mips_lsu_if
// Memory-side port of the MIPS231 load/store unit: one valid/ready request
// channel plus a read-response strobe.
//
//   req_valid  LSU -> mem  request valid, held until req_ready
//   req_ready  mem -> LSU  memory accepts the request this cycle
//   req_we     LSU -> mem  1 = write, 0 = read
//   req_addr   LSU -> mem  word-aligned byte address
//   req_be     LSU -> mem  byte enables, bit n = byte lane n (little-endian)
//   req_wdata  LSU -> mem  store data replicated into every lane
//   resp_valid mem -> LSU  read data valid
//   resp_rdata mem -> LSU  raw 32-bit read word
//
// Modports: master = LSU side, slave = memory side.
// ---------------------------------------------------------------------------
interface mips_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;

    modport master (
        output req_valid,
        output req_we,
        output req_addr,
        output req_be,
        output req_wdata,
        input  req_ready,
        input  resp_valid,
        input  resp_rdata
    );

    modport slave (
        input  req_valid,
        input  req_we,
        input  req_addr,
        input  req_be,
        input  req_wdata,
        output req_ready,
        output resp_valid,
        output resp_rdata
    );
endinterface

// File: rtl/mips_lsu.sv
// ---------------------------------------------------------------------------
// mips_lsu
// Load/store unit sitting behind the ALU. Turns LB/LBU/LH/LHU/LW/SB/SH/SW
// into word-aligned, byte-enabled requests, stalls the core until each access
// finishes, and returns the extended load result for writeback.
//
// Ports
//   clk              rising-edge clock
//   rst_n            asynchronous active-low reset
//   i_mem_read       instruction is a load
//   i_mem_write      instruction is a store (wins over i_mem_read)
//   i_size           00 byte, 01 half, 10 word, 11 illegal
//   i_load_unsigned  zero-extend byte/half loads
//   i_addr           effective address from the ALU
//   i_store_data     rt value, right-aligned
//   o_stall          core must hold PC and inputs
//   o_load_data      extended load result, valid in DONE
//   o_acc_err        misaligned / illegal-size pulse (combinational, IDLE)
//   o_bus_err        response timeout, high during DONE of that access
//   mem              memory request/response port (master side)
//
// Parameter
//   TIMEOUT          WAIT cycles allowed before a read is declared failed
// ---------------------------------------------------------------------------
module mips_lsu #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic [1:0]  i_size,
    input  logic        i_load_unsigned,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_store_data,
    output logic        o_stall,
    output logic [31:0] o_load_data,
    output logic        o_acc_err,
    output logic        o_bus_err,
    mips_lsu_if.master  mem
);

    localparam int unsigned CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    // The counter is compared one short of TIMEOUT so that exactly TIMEOUT
    // WAIT cycles elapse before the timeout transition.
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Request registers
    logic        r_req_valid;
    logic        r_req_we;
    logic [31:0] r_req_addr;
    logic [3:0]  r_req_be;
    logic [31:0] r_req_wdata;

    // Access attributes captured in IDLE for the response path
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [1:0]  r_lane;

    logic [CW-1:0] r_cnt;
    logic [31:0]   r_load_data;
    logic          r_bus_err;

    // Decode / datapath wires
    logic        w_access;
    logic        w_misaligned;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_shifted;
    logic [31:0] w_ext;
    logic        w_timeout;

    // -----------------------------------------------------------------------
    // Access decode
    // -----------------------------------------------------------------------
    assign w_access     = i_mem_read | i_mem_write;
    assign w_misaligned = (i_size == 2'b11)
                        | ((i_size == 2'b01) & i_addr[0])
                        | ((i_size == 2'b10) & (|i_addr[1:0]));

    always_comb begin
        w_be = 4'b1111;
        unique case (i_size)
            2'b00:   w_be = 4'b0001 << i_addr[1:0];
            2'b01:   w_be = 4'b0011 << i_addr[1:0];
            default: w_be = 4'b1111;
        endcase
    end

    // Store data is replicated so the enabled lanes always hold the right
    // bytes regardless of offset; memory only looks at enabled lanes.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_wlane
            assign w_wdata[8*gi +: 8] =
                (i_size == 2'b00) ? i_store_data[7:0] :
                (i_size == 2'b01) ? i_store_data[8*(gi%2) +: 8] :
                                    i_store_data[8*gi +: 8];
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Read extraction: bring the addressed lane down to bit 0, then extend.
    // -----------------------------------------------------------------------
    assign w_shifted = mem.resp_rdata >> {r_lane, 3'b000};

    always_comb begin
        w_ext = mem.resp_rdata;
        unique case (r_size)
            2'b00:   w_ext = r_unsigned ? {24'd0, w_shifted[7:0]}
                                        : {{24{w_shifted[7]}}, w_shifted[7:0]};
            2'b01:   w_ext = r_unsigned ? {16'd0, w_shifted[15:0]}
                                        : {{16{w_shifted[15]}}, w_shifted[15:0]};
            default: w_ext = mem.resp_rdata;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state and combinational outputs.
    // The IDLE-cycle stall/acc_err are qualified with rst_n so that holding
    // reset releases the core at once even while its access inputs are up.
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        o_stall      = 1'b0;
        o_acc_err    = 1'b0;
        w_timeout    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_access && rst_n) begin
                    if (w_misaligned) begin
                        o_acc_err = 1'b1;
                    end else begin
                        o_stall      = 1'b1;
                        w_state_next = S_REQ;
                    end
                end
            end
            S_REQ: begin
                o_stall = 1'b1;
                if (mem.req_ready) begin
                    w_state_next = r_req_we ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                o_stall = 1'b1;
                if (mem.resp_valid) begin
                    w_state_next = S_DONE;
                end else if (r_cnt == CNT_LAST) begin
                    w_timeout    = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_valid <= 1'b0;
            r_req_we    <= 1'b0;
            r_req_addr  <= 32'd0;
            r_req_be    <= 4'd0;
            r_req_wdata <= 32'd0;
            r_size      <= 2'd0;
            r_unsigned  <= 1'b0;
            r_lane      <= 2'd0;
            r_cnt       <= '0;
            r_load_data <= 32'd0;
            r_bus_err   <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_state_next == S_REQ) begin
                        r_req_valid <= 1'b1;
                        r_req_we    <= i_mem_write;
                        r_req_addr  <= {i_addr[31:2], 2'b00};
                        r_req_be    <= w_be;
                        r_req_wdata <= w_wdata;
                        r_size      <= i_size;
                        r_unsigned  <= i_load_unsigned;
                        r_lane      <= i_addr[1:0];
                    end
                end
                S_REQ: begin
                    if (mem.req_ready) begin
                        r_req_valid <= 1'b0;
                        r_cnt       <= '0;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + CNT_ONE;
                    if (mem.resp_valid) begin
                        r_load_data <= w_ext;
                    end else if (w_timeout) begin
                        r_load_data <= 32'd0;
                        r_bus_err   <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_bus_err <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign mem.req_valid = r_req_valid;
    assign mem.req_we    = r_req_we;
    assign mem.req_addr  = r_req_addr;
    assign mem.req_be    = r_req_be;
    assign mem.req_wdata = r_req_wdata;

    assign o_load_data = r_load_data;
    assign o_bus_err   = r_bus_err;

endmodule

// File: tb/tb_mips_lsu.sv
module tb_mips_lsu;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        load_unsigned = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] store_data = 32'd0;
    logic        stall;
    logic [31:0] load_data;
    logic        acc_err;
    logic        bus_err;

    mips_lsu_if bus();

    mips_lsu #(.TIMEOUT(T)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_mem_read      (mem_read),
        .i_mem_write     (mem_write),
        .i_size          (size),
        .i_load_unsigned (load_unsigned),
        .i_addr          (addr),
        .i_store_data    (store_data),
        .o_stall         (stall),
        .o_load_data     (load_data),
        .o_acc_err       (acc_err),
        .o_bus_err       (bus_err),
        .mem             (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // -------------------------------------------------------------------
    // Memory responder: ready after m_rdy cycles of req_valid, read data
    // m_dly cycles after the read handshake. Outside those windows it
    // toggles ready/resp_valid randomly, which the LSU must ignore.
    // -------------------------------------------------------------------
    int          m_rdy = 0;
    int          m_dly = 0;
    logic [31:0] m_rdata = 32'd0;
    int          vcnt = 0;
    int          rcnt = 0;
    bit          pending = 0;

    initial begin
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_rdata = 32'd0;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            bus.req_ready  = 1'b0;
            bus.resp_valid = 1'b0;
            pending = 0;
            vcnt = 0;
            rcnt = 0;
        end else begin
            if (pending) begin
                bus.resp_valid = 1'b0;
                bus.resp_rdata = $urandom;
                if (rcnt == m_dly) begin
                    bus.resp_valid = 1'b1;
                    bus.resp_rdata = m_rdata;
                    pending = 0;
                end
                rcnt++;
                if (rcnt > T + 2) pending = 0;
            end else begin
                bus.resp_valid = 1'($urandom_range(0, 1));
                bus.resp_rdata = $urandom;
            end
            if (bus.req_valid) begin
                bus.req_ready = (vcnt >= m_rdy);
                if (bus.req_ready && !bus.req_we) begin
                    pending = 1;
                    rcnt = 0;
                end
                vcnt++;
            end else begin
                vcnt = 0;
                bus.req_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    // -------------------------------------------------------------------
    // Vector record
    // -------------------------------------------------------------------
    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] ad;
        logic [31:0] sdata;
        int          rdy;
        int          dly;
        logic [31:0] rdata;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] ld;
        logic        berr;
        logic        acc;
        int          stalls;
    } vec_t;

    function automatic vec_t mk(logic rd, logic wr, logic [1:0] sz, logic uns,
                                logic [31:0] ad, logic [31:0] sdata, int rdy, int dly,
                                logic [31:0] rdata, logic [3:0] be, logic [31:0] wdata,
                                logic [31:0] ld, logic berr, logic acc, int stalls);
        vec_t v;
        v.rd = rd; v.wr = wr; v.sz = sz; v.uns = uns; v.ad = ad; v.sdata = sdata;
        v.rdy = rdy; v.dly = dly; v.rdata = rdata; v.be = be; v.wdata = wdata;
        v.ld = ld; v.berr = berr; v.acc = acc; v.stalls = stalls;
        return v;
    endfunction

    // Reference model: access size in bytes, byte offset within the word,
    // byte-range enables, modular lane replication, little-endian assembly
    // of the loaded bytes and two's-complement extension by subtraction.
    function automatic vec_t model(vec_t v);
        int     n;
        int     off;
        longint val;
        n   = (v.sz == 2'b00) ? 1 : (v.sz == 2'b01) ? 2 : 4;
        off = int'(v.ad[1:0]);
        v.acc   = (v.sz == 2'b11) || ((off % n) != 0);
        v.be    = 4'b0000;
        v.wdata = 32'd0;
        v.ld    = 32'd0;
        v.berr  = 1'b0;
        if (v.acc) begin
            v.stalls = 0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (k >= off && k < off + n) v.be[k] = 1'b1;
                v.wdata[8*k +: 8] = v.sdata[8*(k % n) +: 8];
            end
            if (v.wr) begin
                v.stalls = v.rdy + 2;
            end else begin
                v.berr   = (v.dly >= T);
                v.stalls = v.rdy + 2 + ((v.dly + 1 < T) ? v.dly + 1 : T);
                val = 0;
                for (int i = 0; i < n; i++)
                    val = val | (longint'(v.rdata[8*(off+i) +: 8]) << (8*i));
                if (!v.uns && n < 4 && ((val >> (8*n - 1)) & 1) == 1)
                    val = val - (longint'(1) << (8*n));
                v.ld = v.berr ? 32'd0 : val[31:0];
            end
        end
        return v;
    endfunction

    // -------------------------------------------------------------------
    // Drive one access, play the core, and compare every observable.
    // -------------------------------------------------------------------
    task automatic apply(input vec_t v, input int idx);
        int          stalls;
        int          nreq;
        bit          done;
        logic [31:0] exp_addr;
        @(negedge clk);
        m_rdy = v.rdy; m_dly = v.dly; m_rdata = v.rdata;
        mem_read = v.rd; mem_write = v.wr; size = v.sz;
        load_unsigned = v.uns; addr = v.ad; store_data = v.sdata;
        exp_addr = v.ad & 32'hFFFF_FFFC;
        stalls = 0; nreq = 0; done = 0;
        for (int c = 0; c < 64; c++) begin
            #1;
            if (bus.req_valid) begin
                nreq++;
                check("req_fields", {59'd0, bus.req_we, bus.req_be, bus.req_addr, bus.req_wdata},
                      {59'd0, v.wr, v.be, exp_addr, v.wdata});
            end
            if (!stall) begin
                done = 1;
                break;
            end
            stalls++;
            @(negedge clk);
        end
        if (!done) check("completion_bound", 96'd0, 96'd1);
        check("stall_cycles", 96'(stalls), 96'(v.stalls));
        check("req_valid_cycles", 96'(nreq), 96'(v.acc ? 0 : v.rdy + 1));
        check("acc_err", 96'(acc_err), 96'(v.acc));
        check("bus_err", 96'(bus_err), 96'(v.berr));
        if (v.rd && !v.wr && !v.acc) check("load_data", 96'(load_data), 96'(v.ld));
        $display("vec %0d rd=%0d wr=%0d sz=%0d uns=%0d addr=%h sdata=%h rdata=%h -> stalls=%0d ld=%h be=%b berr=%0d acc=%0d",
                 idx, v.rd, v.wr, v.sz, v.uns, v.ad, v.sdata, v.rdata, stalls, load_data,
                 bus.req_be, bus_err, acc_err);
        @(negedge clk);
        mem_read = 1'b0; mem_write = 1'b0;
        #1;
        check("idle_after", {92'd0, stall, bus_err, acc_err, bus.req_valid}, 96'd0);
    endtask

    vec_t dir_vecs[16];

    initial begin
        vec_t v;

        // SW/SB/SH, byte/half/word loads, backpressure, misaligned,
        // timeout and the last-cycle response boundary.
        dir_vecs[0]  = mk(0,1,2'b10,0,32'h100,32'hDEADBEEF,0,0,32'h0, 4'hF,32'hDEADBEEF,32'h0,0,0,2);
        dir_vecs[1]  = mk(0,1,2'b00,0,32'h103,32'h000000A5,0,0,32'h0, 4'h8,32'hA5A5A5A5,32'h0,0,0,2);
        dir_vecs[2]  = mk(1,0,2'b00,0,32'h102,32'h0,0,0,32'h12F03456, 4'h4,32'h0,32'hFFFFFFF0,0,0,3);
        dir_vecs[3]  = mk(1,0,2'b00,1,32'h102,32'h0,0,0,32'h12F03456, 4'h4,32'h0,32'h000000F0,0,0,3);
        dir_vecs[4]  = mk(1,0,2'b01,0,32'h102,32'h0,0,0,32'h12F03456, 4'hC,32'h0,32'h000012F0,0,0,3);
        dir_vecs[5]  = mk(1,0,2'b10,0,32'h204,32'h0,3,1,32'hCAFEF00D, 4'hF,32'h0,32'hCAFEF00D,0,0,7);
        dir_vecs[6]  = mk(1,0,2'b10,0,32'h102,32'h0,0,0,32'h0, 4'h0,32'h0,32'h0,0,1,0);
        dir_vecs[7]  = mk(0,1,2'b01,0,32'h101,32'h5555,0,0,32'h0, 4'h0,32'h0,32'h0,0,1,0);
        dir_vecs[8]  = mk(1,0,2'b10,0,32'h200,32'h0,0,99,32'h12345678, 4'hF,32'h0,32'h0,1,0,6);
        dir_vecs[9]  = mk(1,0,2'b10,0,32'h300,32'h0,0,3,32'h89ABCDEF, 4'hF,32'h0,32'h89ABCDEF,0,0,6);
        dir_vecs[10] = mk(0,1,2'b01,0,32'h102,32'h1234BEEF,1,0,32'h0, 4'hC,32'hBEEFBEEF,32'h0,0,0,3);
        dir_vecs[11] = mk(1,0,2'b11,0,32'h000,32'h0,0,0,32'h0, 4'h0,32'h0,32'h0,0,1,0);
        dir_vecs[12] = mk(1,1,2'b00,0,32'h001,32'h0000007E,0,0,32'h0, 4'h2,32'h7E7E7E7E,32'h0,0,0,2);
        dir_vecs[13] = mk(1,0,2'b01,1,32'h000,32'h0,0,0,32'h00008001, 4'h3,32'h0,32'h00008001,0,0,3);
        dir_vecs[14] = mk(1,0,2'b01,0,32'h000,32'h0,0,0,32'h00008001, 4'h3,32'h0,32'hFFFF8001,0,0,3);
        dir_vecs[15] = mk(1,0,2'b00,0,32'h003,32'h0,0,0,32'h7F000000, 4'h8,32'h0,32'h0000007F,0,0,3);

        // Reset state
        #2;
        check("reset_outputs", {27'd0, stall, acc_err, bus_err, bus.req_valid, bus.req_we,
                                bus.req_be, bus.req_addr, load_data},
              96'd0);
        check("reset_wdata", {64'd0, bus.req_wdata}, 96'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) apply(dir_vecs[i], i);

        // Randomised accesses checked against the reference model
        for (int i = 0; i < 150; i++) begin
            int r;
            r = $urandom_range(1, 3);
            v.rd = r[0]; v.wr = r[1];
            r = $urandom_range(0, 9);
            v.sz = (r < 9) ? 2'(r % 3) : 2'b11;
            v.uns   = 1'($urandom_range(0, 1));
            v.ad    = $urandom;
            v.sdata = $urandom;
            v.rdy   = $urandom_range(0, 3);
            v.dly   = $urandom_range(0, 5);
            v.rdata = $urandom;
            v = model(v);
            apply(v, 100 + i);
        end

        // Reset while waiting for read data
        @(negedge clk);
        m_rdy = 0; m_dly = 99; m_rdata = 32'h0;
        mem_read = 1'b1; mem_write = 1'b0; size = 2'b10; addr = 32'h400; load_unsigned = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("wait_stalled", {95'd0, stall}, 96'd1);
        rst_n = 1'b0;
        #1;
        check("rst_in_wait", {94'd0, bus.req_valid, stall}, 96'd0);
        $display("seq reset-in-wait: req_valid=%0d stall=%0d", bus.req_valid, stall);
        @(negedge clk);
        mem_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Reset while a store request is back-pressured
        @(negedge clk);
        m_rdy = 99;
        mem_write = 1'b1; size = 2'b10; addr = 32'h500; store_data = 32'h0BADF00D;
        repeat (3) @(negedge clk);
        #1;
        check("req_held", {58'd0, bus.req_valid, stall, bus.req_addr, bus.req_wdata},
              {58'd0, 1'b1, 1'b1, 32'h500, 32'h0BADF00D});
        rst_n = 1'b0;
        #1;
        check("rst_in_req", {94'd0, bus.req_valid, stall}, 96'd0);
        $display("seq reset-in-req: req_valid=%0d stall=%0d", bus.req_valid, stall);
        @(negedge clk);
        mem_write = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Normal access after the abandoned ones
        apply(dir_vecs[2], 900);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mips_lsu.md
Name: mips_lsu

Overview:
- Load/store unit directly downstream of the 32-bit ALU in the MIPS231 datapath; the ALU result is the effective address.
- Converts LB/LBU/LH/LHU/LW/SB/SH/SW into word-aligned, byte-enabled requests on a valid/ready memory port.
- Stalls the core until each access completes and returns the sign- or zero-extended load data for writeback.
- Detects misaligned or illegal accesses and enforces a response timeout.

Parameters:
- TIMEOUT, default 255: max cycles in WAIT before bus error; counter width is clog2(TIMEOUT+1).

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- mem_read  in  1  current instruction is a load
- mem_write  in  1  current instruction is a store
- size  in  2  00 byte, 01 half, 10 word, 11 illegal
- load_unsigned  in  1  1 = zero-extend (LBU/LHU)
- addr  in  32  effective address (ALU out)
- store_data  in  32  rt value, right-aligned
- stall  out  1  core must hold PC and all inputs stable
- load_data  out  32  extended load result, valid in DONE
- acc_err  out  1  misaligned or illegal size; one-cycle pulse
- bus_err  out  1  response timeout; one-cycle pulse in DONE
- req_valid  out  1  memory request valid
- req_ready  in  1  memory accepts request
- req_we  out  1  1 = write
- req_addr  out  32  {addr[31:2],2'b00}
- req_be  out  4  byte enables, little-endian
- req_wdata  out  32  lane-replicated store data
- resp_valid  in  1  read data valid
- resp_rdata  in  32  raw word read data

Behaviour:
- Reset values: state = IDLE; req_valid, req_we, req_be, stall, acc_err, bus_err = 0; req_addr, req_wdata, load_data = 0; timeout counter = 0.
- Access decode: access = mem_read | mem_write. If both are set, the store wins.
- Misaligned: half with addr[0] = 1, word with addr[1:0] != 0, or size = 11.
- States: IDLE, REQ, WAIT, DONE.
- IDLE, access and legal:
  - stall = 1 (combinational).
  - Register req_addr, req_we, req_be and req_wdata; go to REQ.
- IDLE, access and misaligned:
  - acc_err = 1 and stall = 0 in the same cycle.
  - No request is issued; the store is suppressed.
  - Remain in IDLE.
- IDLE, no access: stall = 0.
- REQ: req_valid = 1, stall = 1. Outputs are held until req_valid & req_ready.
  - On handshake, a write goes to DONE and a read goes to WAIT (counter cleared).
- WAIT: stall = 1; the counter increments each cycle.
  - On resp_valid: extract and extend into load_data; go to DONE.
  - When the counter reaches TIMEOUT without resp_valid: load_data = 0, set the bus_err flag; go to DONE.
- DONE: stall = 0; load_data is valid; bus_err reflects this access.
  - The core advances at this clock edge. Next state is IDLE; bus_err clears.
- Latency with zero-wait memory: a store stalls 2 cycles and retires in cycle 3; a load stalls 3 cycles and retires in cycle 4.
- Byte enables:
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 << addr[1:0]
  - word: 4'b1111
- Write data:
  - byte: {4{store_data[7:0]}}
  - half: {2{store_data[15:0]}}
  - word: store_data
- Read extraction: lane = resp_rdata >> (8*addr[1:0]). The byte or half is sign-extended unless load_unsigned; word passes unchanged.
- resp_valid outside WAIT is ignored. req_ready outside REQ is ignored.
- Asynchronous reset in any state: immediately return to IDLE and drop req_valid. The memory side must tolerate the abandoned request.
- Inputs are sampled only in IDLE. Changes while stall = 1 are a core protocol violation and have no effect.

Test Plan:
- SW addr 0x100, data 0xDEADBEEF, req_ready always 1 -> req_be = 1111, req_wdata = 0xDEADBEEF, req_addr = 0x100, stall high for exactly 2 cycles.
- SB addr 0x103, data 0x000000A5 -> req_be = 1000, req_wdata = 0xA5A5A5A5, req_addr = 0x100.
- LB addr 0x102, resp_rdata = 0x12F03456 -> load_data = 0xFFFFFFF0. Same access as LBU -> 0x000000F0. LH addr 0x102 -> 0x000012F0.
- LW addr 0x204, req_ready low 3 cycles, resp_valid 2 cycles after handshake -> req_valid and req_addr held during backpressure; load_data = resp_rdata in DONE.
- LW addr 0x102, then SH addr 0x101 -> acc_err pulse, no req_valid, stall = 0, no write.
- LW with no resp_valid, TIMEOUT = 4 -> bus_err = 1 and load_data = 0 in DONE after 4 WAIT cycles. Separately, assert rst_n low during WAIT -> req_valid = 0 and stall = 0 immediately.
